// File: rtl/posit_decode_pkg.sv
// Shared definitions for the posit (es=3) unpacker: field widths, FSM state
// encoding and the regime-value helper. The same field set is consumed by
// round_off on the output side.
package posit_decode_pkg;

    localparam int N  = 32;  // posit width
    localparam int ES = 3;   // exponent field width
    localparam int KW = 6;   // signed regime width, range -31..+30
    localparam int MW = 32;  // mantissa width, bit MW-1 is the hidden 1

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        SCAN     = 3'd2,
        EXTRACT  = 3'd3,
        COMPLETE = 3'd4
    } state_t;

    // A run of m ones encodes k = m-1; a run of m zeros encodes k = -m.
    function automatic logic [KW-1:0] regime_k(input logic r0, input logic [4:0] m);
        logic [KW-1:0] mx;
        mx = KW'(m);
        return r0 ? (mx - KW'(1)) : (-mx);
    endfunction

endpackage

// File: rtl/posit_decode_if.sv
// Request/result bundle of the posit unpacker.
//   start, posit_in             : requester -> decoder (start is a level)
//   sign_out, k_out, exp_out,
//   mantissa_out, zero_out,
//   nar_out, busy, done         : decoder -> requester
interface posit_decode_if;
    import posit_decode_pkg::*;

    logic          start;
    logic [N-1:0]  posit_in;
    logic          sign_out;
    logic [KW-1:0] k_out;
    logic [ES-1:0] exp_out;
    logic [MW-1:0] mantissa_out;
    logic          zero_out;
    logic          nar_out;
    logic          busy;
    logic          done;

    modport master (
        output start, posit_in,
        input  sign_out, k_out, exp_out, mantissa_out, zero_out, nar_out, busy, done
    );

    modport slave (
        input  start, posit_in,
        output sign_out, k_out, exp_out, mantissa_out, zero_out, nar_out, busy, done
    );

endinterface

// File: rtl/posit_field_extract.sv
// Combinational exponent/fraction splitter.
//   word_i : working (non-negative) posit word
//   rem_i  : number of bits left below the regime terminator (0 if none)
//   exp_o  : next ES bits below the terminator, zero-padded at the LSBs
//   frac_o : remaining bits, left-aligned, zero fill (hidden bit excluded)
module posit_field_extract
    import posit_decode_pkg::*;
(
    input  logic [N-1:0]  word_i,
    input  logic [4:0]    rem_i,
    output logic [ES-1:0] exp_o,
    output logic [MW-2:0] frac_o
);

    logic [5:0]   sh;
    logic [N-1:0] aligned;

    // Shift the bits below the terminator up to the MSB; anything short of a
    // full exponent field naturally fills with zeros from the right.
    assign sh      = 6'(N) - {1'b0, rem_i};
    assign aligned = word_i << sh;

    assign exp_o  = aligned[N-1 -: ES];
    assign frac_o = {aligned[N-ES-1:0], {(MW-1-(N-ES)){1'b0}}};

endmodule

// File: rtl/posit_decode.sv
// Multi-cycle unpacker for 32-bit posits (es=3). Scans the regime one bit per
// cycle, then splits exponent and fraction in a single EXTRACT step.
//   clk : rising-edge clock
//   rst : synchronous reset, active high
//   bus : posit_decode_if.slave (start/posit_in in, decoded fields + busy/done out)
module posit_decode
    import posit_decode_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    posit_decode_if.slave bus
);

    state_t        state_q, state_d;
    logic [N-1:0]  word_q, word_d;
    logic          r0_q, r0_d;
    logic [4:0]    idx_q, idx_d;
    logic [4:0]    m_q, m_d;
    logic          term_q, term_d;
    logic          sign_q, sign_d;
    logic [KW-1:0] k_q, k_d;
    logic [ES-1:0] exp_q, exp_d;
    logic [MW-1:0] mant_q, mant_d;
    logic          zero_q, zero_d;
    logic          nar_q, nar_d;

    logic [N-1:0]  mag;
    logic [4:0]    rem;
    logic [ES-1:0] fx_exp;
    logic [MW-2:0] fx_frac;

    // Negative posits are decoded from their two's complement.
    assign mag = word_q[N-1] ? (-word_q) : word_q;
    // Without a terminator the regime consumed every bit.
    assign rem = term_q ? idx_q : 5'd0;

    posit_field_extract u_fx (
        .word_i (word_q),
        .rem_i  (rem),
        .exp_o  (fx_exp),
        .frac_o (fx_frac)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        r0_d    = r0_q;
        idx_d   = idx_q;
        m_d     = m_q;
        term_d  = term_q;
        sign_d  = sign_q;
        k_d     = k_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        zero_d  = zero_q;
        nar_d   = nar_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    word_d  = bus.posit_in;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                sign_d  = 1'b0;
                k_d     = '0;
                exp_d   = '0;
                mant_d  = '0;
                zero_d  = 1'b0;
                nar_d   = 1'b0;
                if (word_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = COMPLETE;
                end else if (word_q == {1'b1, {(N-1){1'b0}}}) begin
                    nar_d   = 1'b1;
                    state_d = COMPLETE;
                end else begin
                    sign_d  = word_q[N-1];
                    word_d  = mag;
                    r0_d    = mag[N-2];
                    idx_d   = 5'(N-2);
                    m_d     = '0;
                    term_d  = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (word_q[idx_q] == r0_q) begin
                    m_d = m_q + 5'd1;
                    if (idx_q == '0) state_d = EXTRACT;
                    else             idx_d   = idx_q - 5'd1;
                end else begin
                    // idx stays on the terminator so rem counts the bits below it
                    term_d  = 1'b1;
                    state_d = EXTRACT;
                end
            end
            EXTRACT: begin
                k_d     = regime_k(r0_q, m_q);
                exp_d   = fx_exp;
                mant_d  = {1'b1, fx_frac};
                state_d = COMPLETE;
            end
            COMPLETE: begin
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            r0_q    <= 1'b0;
            idx_q   <= '0;
            m_q     <= '0;
            term_q  <= 1'b0;
            sign_q  <= 1'b0;
            k_q     <= '0;
            exp_q   <= '0;
            mant_q  <= '0;
            zero_q  <= 1'b0;
            nar_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            r0_q    <= r0_d;
            idx_q   <= idx_d;
            m_q     <= m_d;
            term_q  <= term_d;
            sign_q  <= sign_d;
            k_q     <= k_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            zero_q  <= zero_d;
            nar_q   <= nar_d;
        end
    end

    assign bus.sign_out     = sign_q;
    assign bus.k_out        = k_q;
    assign bus.exp_out      = exp_q;
    assign bus.mantissa_out = mant_q;
    assign bus.zero_out     = zero_q;
    assign bus.nar_out      = nar_q;
    assign bus.done         = (state_q == COMPLETE);
    assign bus.busy         = (state_q != IDLE) && (state_q != COMPLETE);

endmodule

// File: tb/tb_posit_decode.sv
module tb_posit_decode;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc;
    int   done_seen;

    posit_decode_if bus ();

    posit_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raise start with posit p and count rising edges (accept edge included)
    // until done is seen; posit_in is scrambled after acceptance.
    task automatic decode(input logic [31:0] p, output int n);
        bus.posit_in = p;
        bus.start    = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) bus.posit_in = ~p;
        end while (!bus.done && n < 100);
    endtask

    task automatic release_start(input string tag);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_fall"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic expect_fields(input string tag, input logic s, input logic [5:0] k,
                                 input logic [2:0] e, input logic [31:0] mant,
                                 input logic z, input logic nr);
        chk({tag, "_sign"}, 32'(bus.sign_out), 32'(s));
        chk({tag, "_k"},    32'(bus.k_out),    32'(k));
        chk({tag, "_exp"},  32'(bus.exp_out),  32'(e));
        chk({tag, "_mant"}, bus.mantissa_out,  mant);
        chk({tag, "_zero"}, 32'(bus.zero_out), 32'(z));
        chk({tag, "_nar"},  32'(bus.nar_out),  32'(nr));
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.posit_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_fields("reset", 1'b0, 6'd0, 3'd0, 32'h0, 1'b0, 1'b0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1.0: minimum-latency path
        decode(32'h4000_0000, cyc);
        chk("p40_cycles", 32'(cyc), 32'd5);
        expect_fields("p40", 1'b0, 6'd0, 3'd0, 32'h8000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_done", 32'(bus.done), 32'd1);
            chk("hold_mant", bus.mantissa_out, 32'h8000_0000);
        end
        release_start("p40");
        chk("idle_keep_mant", bus.mantissa_out, 32'h8000_0000);

        decode(32'h4A00_0000, cyc);
        chk("p4a_cycles", 32'(cyc), 32'd5);
        expect_fields("p4a", 1'b0, 6'd0, 3'd2, 32'hC000_0000, 1'b0, 1'b0);
        release_start("p4a");

        decode(32'hC000_0000, cyc);
        chk("pc0_cycles", 32'(cyc), 32'd5);
        expect_fields("pc0", 1'b1, 6'd0, 3'd0, 32'h8000_0000, 1'b0, 1'b0);
        release_start("pc0");

        // run of three zeros, exp=3, fraction .01
        decode(32'h0B40_0000, cyc);
        chk("p0b4_cycles", 32'(cyc), 32'd7);
        expect_fields("p0b4", 1'b0, 6'b111101, 3'd3, 32'hA000_0000, 1'b0, 1'b0);
        release_start("p0b4");

        // no terminator: 31 SCAN cycles
        decode(32'h7FFF_FFFF, cyc);
        chk("pmax_cycles", 32'(cyc), 32'd34);
        expect_fields("pmax", 1'b0, 6'b011110, 3'd0, 32'h8000_0000, 1'b0, 1'b0);
        release_start("pmax");

        decode(32'h0000_0001, cyc);
        chk("pmin_cycles", 32'(cyc), 32'd34);
        expect_fields("pmin", 1'b0, 6'b100010, 3'd0, 32'h8000_0000, 1'b0, 1'b0);
        release_start("pmin");

        // one bit left below the terminator: exponent padded to 3'b100
        decode(32'h7FFF_FFFD, cyc);
        chk("ptrunc_cycles", 32'(cyc), 32'd33);
        expect_fields("ptrunc", 1'b0, 6'd28, 3'b100, 32'h8000_0000, 1'b0, 1'b0);
        release_start("ptrunc");

        decode(32'h0000_0000, cyc);
        chk("zero_cycles", 32'(cyc), 32'd2);
        expect_fields("zero", 1'b0, 6'd0, 3'd0, 32'h0, 1'b1, 1'b0);
        release_start("zero");

        decode(32'h8000_0000, cyc);
        chk("nar_cycles", 32'(cyc), 32'd2);
        expect_fields("nar", 1'b0, 6'd0, 3'd0, 32'h0, 1'b0, 1'b1);
        release_start("nar");

        // reset while scanning a negative posit (sign_out already set)
        bus.posit_in = 32'h8000_0001;
        bus.start    = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd1);
        chk("abort_sign_pre", 32'(bus.sign_out), 32'd1);
        rst       = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        expect_fields("abort", 1'b0, 6'd0, 3'd0, 32'h0, 1'b0, 1'b0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_busy_clr", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);

        // -6.0 after the abort
        decode(32'hB600_0000, cyc);
        chk("after_cycles", 32'(cyc), 32'd5);
        expect_fields("after", 1'b1, 6'd0, 3'd2, 32'hC000_0000, 1'b0, 1'b0);
        release_start("after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
